// File: rtl/buflet_page_map.sv
// Free-page allocator: hands out the lowest free page, takes pages back, flags illegal frees.
// Latency: grant pulses two cycles after a request is seen while idle (one op in flight at a time).
// Backpressure: req is held until its one-cycle gnt; alloc stalls while the pool is empty, free wins ties.
//
// Ports:
//   clk, reset_l                       clock, asynchronous active-low reset
//   free_req/free_gnt/free_page/free_who   page return handshake (who is only reported on error)
//   alloc_req/alloc_gnt/alloc_page         allocation handshake; alloc_page held until next grant
//   double_free_error/_page/_who           one-cycle error pulse with captured page/client
//   count                                  number of free pages in the pool
//
// Organisation: a 32-bit-wide bitmap RAM (1 = free) plus two summary levels held in flops:
// l1_q[i][j] says bitmap word {i,j} has a free bit, l0_q[i] says l1_q[i] is non-zero.
// The summaries locate the lowest free word in one cycle; the RAM word is then read and
// rewritten. Ops are strictly serialised, so a word is never read while a write to it is
// still outstanding. The two-level summary assumes a 10-bit word address (PAGE_W = 15).
module buflet_page_map #(
    parameter int          PAGE_W   = 15,
    parameter logic [15:0] FIRST_PG = 16'h0C00,
    parameter int          WHO_W    = 4
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              free_req,
    output logic              free_gnt,
    input  logic [PAGE_W-1:0] free_page,
    input  logic [WHO_W-1:0]  free_who,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PAGE_W-1:0] alloc_page,
    output logic              double_free_error,
    output logic [PAGE_W-1:0] double_free_page,
    output logic [WHO_W-1:0]  double_free_who,
    output logic [15:0]       count
);

    localparam int          WA_W       = PAGE_W - 5;
    localparam int          NWORDS     = 1 << WA_W;
    localparam int          FIRST_WORD = int'(FIRST_PG) >> 5;
    localparam logic [15:0] POOL       = 16'((1 << PAGE_W) - int'(FIRST_PG));

    typedef enum logic [1:0] {
        S_INIT,   // sweeping the bitmap RAM after reset
        S_IDLE,   // accepting a request; RAM read issued on leaving
        S_FREE,   // read data back: validate and set the page bit
        S_ALLOC   // read data back: clear the lowest set bit
    } state_t;

    state_t state_q, state_d;

    logic [WA_W-1:0]   sweep_q;
    logic [31:0]       l0_q;
    logic [31:0]       l1_q [32];
    logic [31:0]       mem  [NWORDS];
    logic [31:0]       rd_q;
    logic [PAGE_W-1:0] op_page_q;
    logic [WHO_W-1:0]  op_who_q;

    logic [4:0]        l0_idx, l1_idx, abit;
    logic [WA_W-1:0]   alloc_word, op_word, rd_addr, mem_wa;
    logic [4:0]        op_bit;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic              take_free, take_alloc, do_free, do_err, do_alloc;

    // Index of the lowest set bit (0 when the vector is empty; callers guard that case).
    function automatic logic [4:0] lsb_idx(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int k = 31; k >= 0; k--) begin
            if (v[k]) r = 5'(k);
        end
        return r;
    endfunction

    always_comb begin
        l0_idx     = lsb_idx(l0_q);
        l1_idx     = lsb_idx(l1_q[l0_idx]);
        alloc_word = {l0_idx, l1_idx};
        op_word    = op_page_q[PAGE_W-1:5];
        op_bit     = op_page_q[4:0];
        abit       = lsb_idx(rd_q);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        rd_addr    = op_word;
        mem_we     = 1'b0;
        mem_wa     = op_word;
        mem_wd     = rd_q;
        take_free  = 1'b0;
        take_alloc = 1'b0;
        do_free    = 1'b0;
        do_err     = 1'b0;
        do_alloc   = 1'b0;
        case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                mem_wa = sweep_q;
                mem_wd = (sweep_q < WA_W'(FIRST_WORD)) ? '0 : '1;
                if (sweep_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                // A request still high during its own grant cycle is the one just served.
                if (free_req && !free_gnt) begin
                    take_free = 1'b1;
                    rd_addr   = free_page[PAGE_W-1:5];
                    state_d   = S_FREE;
                end else if (alloc_req && !alloc_gnt && count != '0) begin
                    take_alloc = 1'b1;
                    rd_addr    = alloc_word;
                    state_d    = S_ALLOC;
                end
            end
            S_FREE: begin
                state_d = S_IDLE;
                // Reserved pages read as used, so they need the explicit range test.
                if (32'(op_page_q) < 32'(FIRST_PG) || rd_q[op_bit]) begin
                    do_err = 1'b1;
                end else begin
                    do_free = 1'b1;
                    mem_we  = 1'b1;
                    mem_wd  = rd_q | (32'b1 << op_bit);
                end
            end
            S_ALLOC: begin
                state_d  = S_IDLE;
                do_alloc = 1'b1;
                mem_we   = 1'b1;
                mem_wd   = rd_q & ~(32'b1 << abit);
            end
            default: state_d = S_INIT;
        endcase
    end

    // Bitmap RAM: contents are established by the post-reset sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sweep_q           <= '0;
            free_gnt          <= 1'b0;
            alloc_gnt         <= 1'b0;
            alloc_page        <= '0;
            double_free_error <= 1'b0;
            double_free_page  <= '0;
            double_free_who   <= '0;
            count             <= POOL;
            op_page_q         <= '0;
            op_who_q          <= '0;
            for (int i = 0; i < 32; i++) begin
                l0_q[i] <= (i * 32 + 31 >= FIRST_WORD);
                for (int j = 0; j < 32; j++) begin
                    l1_q[i][j] <= (i * 32 + j >= FIRST_WORD);
                end
            end
        end else begin
            free_gnt          <= do_free | do_err;
            alloc_gnt         <= do_alloc;
            double_free_error <= do_err;
            if (state_q == S_INIT) sweep_q <= sweep_q + 1'b1;
            if (take_free) begin
                op_page_q <= free_page;
                op_who_q  <= free_who;
            end
            if (take_alloc) op_page_q <= {alloc_word, 5'd0};
            if (do_err) begin
                double_free_page <= op_page_q;
                double_free_who  <= op_who_q;
            end
            if (do_free) begin
                count <= count + 16'd1;
                l1_q[op_word[WA_W-1:5]][op_word[4:0]] <= 1'b1;
                l0_q[op_word[WA_W-1:5]]               <= 1'b1;
            end
            if (do_alloc) begin
                count      <= count - 16'd1;
                alloc_page <= {op_word, abit};
                // Word now fully used: drop its summary bit, and the top bit if the group empties.
                if (mem_wd == '0) begin
                    l1_q[op_word[WA_W-1:5]][op_word[4:0]] <= 1'b0;
                    if ((l1_q[op_word[WA_W-1:5]] & ~(32'b1 << op_word[4:0])) == '0)
                        l0_q[op_word[WA_W-1:5]] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_buflet_page_map.sv
// Bench for buflet_page_map. The main instance uses a reduced pool (first page 0x7800) so the
// exhaustive alloc/free sweeps stay short; a second instance with default parameters pins the
// 0x0C00 boundary and the 0x7400 reset count.
module tb_buflet_page_map;

    localparam int FP   = 'h7800;
    localparam int POOL = 32768 - FP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_l;
    logic        free_req, free_gnt, alloc_req, alloc_gnt, double_free_error;
    logic [14:0] free_page, alloc_page, double_free_page;
    logic [3:0]  free_who, double_free_who;
    logic [15:0] count;

    logic        d0_free_req, d0_free_gnt, d0_alloc_req, d0_alloc_gnt, d0_err;
    logic [14:0] d0_free_page, d0_alloc_page, d0_err_page;
    logic [3:0]  d0_free_who, d0_err_who;
    logic [15:0] d0_count;

    buflet_page_map #(.PAGE_W(15), .FIRST_PG(16'h7800), .WHO_W(4)) dut (
        .clk(clk), .reset_l(reset_l),
        .free_req(free_req), .free_gnt(free_gnt), .free_page(free_page), .free_who(free_who),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_page(alloc_page),
        .double_free_error(double_free_error), .double_free_page(double_free_page),
        .double_free_who(double_free_who), .count(count)
    );

    buflet_page_map d0 (
        .clk(clk), .reset_l(reset_l),
        .free_req(d0_free_req), .free_gnt(d0_free_gnt), .free_page(d0_free_page), .free_who(d0_free_who),
        .alloc_req(d0_alloc_req), .alloc_gnt(d0_alloc_gnt), .alloc_page(d0_alloc_page),
        .double_free_error(d0_err), .double_free_page(d0_err_page),
        .double_free_who(d0_err_who), .count(d0_count)
    );

    int checks = 0;
    int passes = 0;
    int err_pulses = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", n, act, exp);
    endtask

    // ---------------- behavioural model: one bit per page, lowest-free by linear scan
    bit model_free [32768];
    int model_cnt;

    task automatic model_reset();
        for (int p = 0; p < 32768; p++) model_free[p] = (p >= FP);
        model_cnt = POOL;
    endtask

    function automatic int lowest_free();
        for (int p = FP; p < 32768; p++) if (model_free[p]) return p;
        return -1;
    endfunction

    always @(negedge clk) begin
        int  e;
        bit  ee;
        if (!reset_l) begin
            model_reset();
            chk("rst_outputs", {free_gnt, alloc_gnt, double_free_error, alloc_page, double_free_page},
                32'h0);
            chk("rst_who", double_free_who, 0);
            chk("rst_count", count, POOL);
        end else begin
            if (double_free_error) err_pulses++;
            if (free_gnt) begin
                ee = (int'(free_page) < FP) || model_free[free_page];
                chk("free_err", double_free_error, ee);
                if (ee) begin
                    chk("err_page", double_free_page, free_page);
                    chk("err_who", double_free_who, free_who);
                end else begin
                    model_free[free_page] = 1'b1;
                    model_cnt++;
                end
            end else begin
                chk("err_without_gnt", double_free_error, 0);
            end
            if (alloc_gnt) begin
                e = lowest_free();
                chk("alloc_page", alloc_page, e);
                if (e >= 0) begin
                    model_free[e] = 1'b0;
                    model_cnt--;
                end
            end
            chk("count", count, model_cnt);
        end
    end

    // ---------------- drivers
    task automatic alloc_op(input int budget, output logic [14:0] pg);
        logic got;
        got = 1'b0;
        pg  = 'x;
        alloc_req = 1'b1;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (alloc_gnt) begin got = 1'b1; pg = alloc_page; end
        end
        @(posedge clk); #1;
        alloc_req = 1'b0;
        chk("alloc_latency", got, 1);
    endtask

    task automatic free_op(input logic [14:0] p, input logic [3:0] w, input int budget);
        logic got;
        got = 1'b0;
        free_page = p;
        free_who  = w;
        free_req  = 1'b1;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (free_gnt) got = 1'b1;
        end
        @(posedge clk); #1;
        free_req = 1'b0;
        chk("free_latency", got, 1);
    endtask

    task automatic d0_alloc(output logic [14:0] pg);
        logic got;
        got = 1'b0;
        pg  = 'x;
        d0_alloc_req = 1'b1;
        for (int c = 0; c < 1200 && !got; c++) begin
            @(negedge clk);
            if (d0_alloc_gnt) begin got = 1'b1; pg = d0_alloc_page; end
        end
        @(posedge clk); #1;
        d0_alloc_req = 1'b0;
        chk("d0_alloc_latency", got, 1);
    endtask

    task automatic d0_free(input logic [14:0] p, input logic [3:0] w);
        logic got;
        got = 1'b0;
        d0_free_page = p;
        d0_free_who  = w;
        d0_free_req  = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (d0_free_gnt) got = 1'b1;
        end
        @(posedge clk); #1;
        d0_free_req = 1'b0;
        chk("d0_free_latency", got, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

    initial begin
        logic [14:0] pg, pa;
        int e0;
        free_req = 0; alloc_req = 0; free_page = 0; free_who = 0;
        d0_free_req = 0; d0_alloc_req = 0; d0_free_page = 0; d0_free_who = 0;
        reset_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", count, 32'h0800);
        chk("d0_reset_count", d0_count, 32'h7400);
        reset_l = 1'b1;

        // 1: drain the pool in ascending order
        alloc_op(1200, pg);
        chk("t1_first", pg, 32'h7800);
        for (int i = 1; i < POOL; i++) alloc_op(4, pg);
        chk("t1_last", pg, 32'h7FFF);
        chk("t1_empty", count, 0);

        // 2: alloc stalls on an empty pool until a free lands
        fork
            alloc_op(40, pa);
            begin
                repeat (10) @(negedge clk);
                @(posedge clk); #1;
                free_op(15'h7A00, 4'd1, 4);
            end
        join
        chk("t2_alloc", pa, 32'h7A00);
        chk("t2_count", count, 0);

        // 3 and 4: each freed page is the very next one allocated
        for (int x = FP; x < 32768; x++) begin
            free_op(15'(x), 4'(x), 4);
            alloc_op(4, pg);
            chk("t3_alloc", pg, x);
        end
        for (int x = 32767; x >= FP; x--) begin
            free_op(15'(x), 4'(x), 4);
            alloc_op(4, pg);
            chk("t4_alloc", pg, x);
        end
        chk("t4_count", count, 0);

        // 5: double free and reserved-page free
        free_op(15'h7A34, 4'd3, 4);
        e0 = err_pulses;
        free_op(15'h7A34, 4'd5, 4);
        chk("t5_pulses", err_pulses - e0, 1);
        chk("t5_page", double_free_page, 32'h7A34);
        chk("t5_who", double_free_who, 5);
        chk("t5_count", count, 1);
        free_op(15'h0100, 4'd7, 4);
        chk("t5_rsv_page", double_free_page, 32'h0100);
        chk("t5_rsv_count", count, 1);
        free_op(15'h77FF, 4'd2, 4);
        chk("t5_edge_page", double_free_page, 32'h77FF);
        chk("t5_edge_count", count, 1);

        // 6: simultaneous requests, free served first and its page handed out
        fork
            alloc_op(8, pa);
            free_op(15'h7810, 4'd4, 4);
        join
        chk("t6_alloc", pa, 32'h7810);
        chk("t6_count", count, 1);

        // reset while an alloc is in flight
        alloc_req = 1'b1;
        @(posedge clk); #1;
        reset_l   = 1'b0;
        alloc_req = 1'b0;
        @(negedge clk);
        chk("t6_reset_count", count, 32'h0800);
        chk("t6_reset_gnt", alloc_gnt, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_l = 1'b1;
        alloc_op(1200, pg);
        chk("t6_after_reset", pg, 32'h7800);

        // default-parameter instance: 0x0C00 boundary
        d0_alloc(pg);
        chk("d0_first", pg, 32'h0C00);
        d0_alloc(pg);
        chk("d0_second", pg, 32'h0C01);
        chk("d0_count2", d0_count, 32'h73FE);
        d0_free(15'h0BFF, 4'd9);
        chk("d0_rsv_page", d0_err_page, 32'h0BFF);
        chk("d0_rsv_who", d0_err_who, 9);
        chk("d0_rsv_count", d0_count, 32'h73FE);
        d0_free(15'h0C00, 4'd1);
        chk("d0_free_count", d0_count, 32'h73FF);
        d0_alloc(pg);
        chk("d0_realloc", pg, 32'h0C00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
